// File: rtl/dct4_pkg.sv
// Shared constants, float/fixed formats and conversion helpers for the
// streaming 4x4 2-D DCT.
package dct4_pkg;
   localparam int FRAC      = 16;
   localparam int CW        = 16;
   localparam int BIAS      = 127;
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 32;

   localparam logic signed [CW-1:0] C1 = 16'sd21407;
   localparam logic signed [CW-1:0] C3 = 16'sd8867;

   localparam logic signed [34:0] SUM_MAX = 35'sd2147483647;
   localparam logic signed [34:0] SUM_MIN = -35'sd2147483648;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
   } fp_t;

   // Value m*2^(e-150) scaled by 2^FRAC; truncates toward zero, saturates symmetric.
   function automatic logic signed [31:0] fp2fix(fp_t f);
      logic [63:0]        mag;
      logic signed [31:0] r;
      int                 sh;
      mag = '0;
      r   = '0;
      sh  = int'(f.e) - 150 + FRAC;
      if (f.e != 8'd0) begin
         if (sh > 40)
            mag = (f.m != 24'd0) ? 64'hffff_ffff : 64'd0;
         else if (sh >= 0)
            mag = {40'd0, f.m} << sh;
         else if (sh > -24)
            mag = {40'd0, f.m} >> (-sh);
         if (mag > 64'h7fff_ffff)
            mag = 64'h7fff_ffff;
         r = f.s ? -$signed(mag[31:0]) : $signed(mag[31:0]);
      end
      return r;
   endfunction

   function automatic fp_t fix2fp(logic signed [31:0] v);
      fp_t        r;
      logic [31:0] mag;
      int          p;
      r   = '0;
      p   = 0;
      mag = v[31] ? (~v + 32'd1) : v;
      for (int i = 0; i < 32; i++)
         if (mag[i]) p = i;
      if (mag != 32'd0) begin
         r.s = v[31];
         r.e = 8'(BIAS + p - FRAC);
         if (p >= 23)
            r.m = 24'(mag >> (p - 23));
         else
            r.m = 24'(mag << (23 - p));
      end
      return r;
   endfunction

   function automatic logic [31:0] sat32(logic signed [34:0] v);
      if (v > SUM_MAX) return 32'h7fff_ffff;
      if (v < SUM_MIN) return 32'h8000_0000;
      return 32'(v);
   endfunction
endpackage

// File: rtl/dct4_1d_fix.sv
// Combinational 4-point orthonormal DCT-II on Q16.16 fixed-point lanes.
module dct4_1d_fix
   import dct4_pkg::*;
(
   input  logic [NUM_LANES-1:0][VEC_W-1:0] x,
   output logic [NUM_LANES-1:0][VEC_W-1:0] y
);
   logic signed [34:0] x0, x1, x2, x3, a, b, s0, s2, t1, t3;
   logic signed [47:0] p1a, p3b, p3a, p1b;

   always_comb begin
      x0  = 35'($signed(x[0]));
      x1  = 35'($signed(x[1]));
      x2  = 35'($signed(x[2]));
      x3  = 35'($signed(x[3]));
      a   = x0 - x3;
      b   = x1 - x2;
      s0  = (x0 + x1 + x2 + x3) >>> 1;
      s2  = (x0 - x1 - x2 + x3) >>> 1;
      p1a = 48'(a) * 48'(C1);
      p3b = 48'(b) * 48'(C3);
      p3a = 48'(a) * 48'(C3);
      p1b = 48'(b) * 48'(C1);
      // Q1.15 coefficients: drop 15 fraction bits before summing
      t1  = 35'(p1a >>> 15) + 35'(p3b >>> 15);
      t3  = 35'(p3a >>> 15) - 35'(p1b >>> 15);
      y[0] = sat32(s0);
      y[1] = sat32(t1);
      y[2] = sat32(s2);
      y[3] = sat32(t3);
   end
endmodule

// File: rtl/dct4_par_2d_fp.sv
// Streaming 4x4 2-D DCT: row DCT per clock, transposing ping-pong block
// buffer, column DCT emitting one column of coefficients per clock.
module dct4_par_2d_fp
   import dct4_pkg::*;
(
   input  logic        x0s,
   input  logic        x1s,
   input  logic        x2s,
   input  logic        x3s,
   input  logic [7:0]  x0e,
   input  logic [7:0]  x1e,
   input  logic [7:0]  x2e,
   input  logic [7:0]  x3e,
   input  logic [23:0] x0,
   input  logic [23:0] x1,
   input  logic [23:0] x2,
   input  logic [23:0] x3,
   output logic        y0s,
   output logic        y1s,
   output logic        y2s,
   output logic        y3s,
   output logic [7:0]  y0e,
   output logic [7:0]  y1e,
   output logic [7:0]  y2e,
   output logic [7:0]  y3e,
   output logic [23:0] y0,
   output logic [23:0] y1,
   output logic [23:0] y2,
   output logic [23:0] y3,
   input  logic        clk,
   input  logic        reset,
   output logic        yy0s,
   output logic        yy1s,
   output logic        yy2s,
   output logic        yy3s,
   output logic [7:0]  yy0e,
   output logic [7:0]  yy1e,
   output logic [7:0]  yy2e,
   output logic [7:0]  yy3e,
   output logic [23:0] yy0,
   output logic [23:0] yy1,
   output logic [23:0] yy2,
   output logic [23:0] yy3
);
   fp_t [NUM_LANES-1:0]                xin;
   logic [NUM_LANES-1:0][VEC_W-1:0]    row_fix, row_dct, col_in, col_dct;

   // [bank][row][col]
   logic [1:0][NUM_LANES-1:0][NUM_LANES-1:0][VEC_W-1:0] buf_q, buf_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                bsel_q, bsel_d, vld_q, vld_d, rd_bank;
   fp_t [NUM_LANES-1:0] yy_q, yy_d, y_q, y_d;

   assign xin[0] = {x0s, x0e, x0};
   assign xin[1] = {x1s, x1e, x1};
   assign xin[2] = {x2s, x2e, x2};
   assign xin[3] = {x3s, x3e, x3};
   assign rd_bank = ~bsel_q;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign row_fix[g] = fp2fix(xin[g]);
      assign col_in[g]  = buf_q[rd_bank][g][cnt_q];
   end

   dct4_1d_fix u_row (.x(row_fix), .y(row_dct));
   dct4_1d_fix u_col (.x(col_in),  .y(col_dct));

   always_comb begin
      cnt_d  = cnt_q + 2'd1;
      bsel_d = bsel_q ^ (cnt_q == 2'd3);
      vld_d  = vld_q | (cnt_q == 2'd3);
      buf_d  = buf_q;
      buf_d[bsel_q][cnt_q] = row_dct;
      yy_d   = '0;
      y_d    = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         yy_d[i] = fix2fp(row_dct[i]);
         // read bank is still the reset-cleared one until the first block lands
         y_d[i]  = vld_q ? fix2fp(col_dct[i]) : '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         bsel_q <= 1'b0;
         vld_q  <= 1'b0;
         buf_q  <= '0;
         yy_q   <= '0;
         y_q    <= '0;
      end else begin
         cnt_q  <= cnt_d;
         bsel_q <= bsel_d;
         vld_q  <= vld_d;
         buf_q  <= buf_d;
         yy_q   <= yy_d;
         y_q    <= y_d;
      end
   end

   assign {y0s, y0e, y0} = y_q[0];
   assign {y1s, y1e, y1} = y_q[1];
   assign {y2s, y2e, y2} = y_q[2];
   assign {y3s, y3e, y3} = y_q[3];
   assign {yy0s, yy0e, yy0} = yy_q[0];
   assign {yy1s, yy1e, yy1} = yy_q[1];
   assign {yy2s, yy2e, yy2} = yy_q[2];
   assign {yy3s, yy3e, yy3} = yy_q[3];
endmodule

// File: tb/tb_dct4_par_2d_fp.sv
// Directed bench for dct4_par_2d_fp: hand-derived float fields packed {s,e,m}.
module tb_dct4_par_2d_fp;
   logic        clk = 1'b0;
   logic        reset;
   logic [32:0] xv [4];
   logic [32:0] yo [4];
   logic [32:0] yyo[4];
   int          total = 0;
   int          bad   = 0;

   logic        x0s, x1s, x2s, x3s;
   logic [7:0]  x0e, x1e, x2e, x3e;
   logic [23:0] x0, x1, x2, x3;
   logic        y0s, y1s, y2s, y3s, yy0s, yy1s, yy2s, yy3s;
   logic [7:0]  y0e, y1e, y2e, y3e, yy0e, yy1e, yy2e, yy3e;
   logic [23:0] y0, y1, y2, y3, yy0, yy1, yy2, yy3;

   localparam logic [32:0] F0 = 33'd0;
   localparam logic [32:0] F2 = {1'b0, 8'd128, 24'h800000};
   localparam logic [32:0] F4 = {1'b0, 8'd129, 24'h800000};
   localparam logic [32:0] F5 = {1'b0, 8'd129, 24'hA00000};
   localparam logic [32:0] F7 = {1'b0, 8'd129, 24'hE00000};

   always #5 clk = ~clk;

   assign {x0s, x0e, x0} = xv[0];
   assign {x1s, x1e, x1} = xv[1];
   assign {x2s, x2e, x2} = xv[2];
   assign {x3s, x3e, x3} = xv[3];
   assign yo[0]  = {y0s, y0e, y0};
   assign yo[1]  = {y1s, y1e, y1};
   assign yo[2]  = {y2s, y2e, y2};
   assign yo[3]  = {y3s, y3e, y3};
   assign yyo[0] = {yy0s, yy0e, yy0};
   assign yyo[1] = {yy1s, yy1e, yy1};
   assign yyo[2] = {yy2s, yy2e, yy2};
   assign yyo[3] = {yy3s, yy3e, yy3};

   dct4_par_2d_fp dut (
      .x0s(x0s), .x1s(x1s), .x2s(x2s), .x3s(x3s),
      .x0e(x0e), .x1e(x1e), .x2e(x2e), .x3e(x3e),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .y0s(y0s), .y1s(y1s), .y2s(y2s), .y3s(y3s),
      .y0e(y0e), .y1e(y1e), .y2e(y2e), .y3e(y3e),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .clk(clk), .reset(reset),
      .yy0s(yy0s), .yy1s(yy1s), .yy2s(yy2s), .yy3s(yy3s),
      .yy0e(yy0e), .yy1e(yy1e), .yy2e(yy2e), .yy3e(yy3e),
      .yy0(yy0), .yy1(yy1), .yy2(yy2), .yy3(yy3)
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // apply a row and step one rising edge; outputs sampled 1 time unit later
   task automatic row(input logic [32:0] a, input logic [32:0] b,
                      input logic [32:0] c, input logic [32:0] d);
      xv[0] = a; xv[1] = b; xv[2] = c; xv[3] = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_y%0d", tag, i), yo[i], F0);
         chk($sformatf("%s_yy%0d", tag, i), yyo[i], F0);
      end
   endtask

   initial begin
      reset = 1'b0;
      xv[0] = F2; xv[1] = F4; xv[2] = F5; xv[3] = F7;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("rst");
      reset = 1'b1;

      // block 0: [2,4,5,7] x2, [2,2,5,7] x2
      row(F2, F4, F5, F7);
      chk("A_yy0", yyo[0], {1'b0, 8'd130, 24'h900000});
      chk("A_yy1", yyo[1], {1'b1, 8'd128, 24'hE25F00});
      chk("A_yy2", yyo[2], F0);
      chk("A_yy3", yyo[3], {1'b1, 8'd126, 24'hB32000});
      chk("e0_y0", yo[0], F0);
      row(F2, F4, F5, F7);
      chk("e1_y0", yo[0], F0);
      row(F2, F2, F5, F7);
      chk("B_yy0", yyo[0], {1'b0, 8'd130, 24'h800000});
      chk("B_yy1", yyo[1], {1'b1, 8'd129, 24'h828100});
      chk("B_yy2", yyo[2], {1'b0, 8'd127, 24'h800000});
      chk("B_yy3", yyo[3], {1'b0, 8'd126, 24'h9B5C00});
      chk("e2_y1", yo[1], F0);
      row(F2, F2, F5, F7);
      for (int i = 0; i < 4; i++) chk($sformatf("e3_y%0d", i), yo[i], F0);

      // block 1: [0,2,2,2] x4 while block 0 columns stream out
      row(F0, F2, F2, F2);
      chk("D_yy0", yyo[0], {1'b0, 8'd128, 24'hC00000});
      chk("b0c0_y0", yo[0], {1'b0, 8'd131, 24'h880000});
      chk("b0c0_y1", yo[1], {1'b0, 8'd126, 24'hEC8400});
      chk("b0c0_y2", yo[2], F0);
      chk("b0c0_y3", yo[3], {1'b1, 8'd125, 24'hC3F000});
      row(F0, F2, F2, F2);
      chk("b0c1_y0", yo[0], {1'b1, 8'd129, 24'hF3B080});
      chk("b0c1_y1", yo[1], {1'b0, 8'd125, 24'hFFFE00});
      chk("b0c1_y2", yo[2], F0);
      chk("b0c1_y3", yo[3], {1'b1, 8'd124, 24'hD41400});
      row(F0, F2, F2, F2);
      chk("b0c2_y0", yo[0], {1'b0, 8'd127, 24'h800000});
      chk("b0c2_y1", yo[1], {1'b1, 8'd126, 24'hEC8400});
      chk("b0c2_y3", yo[3], {1'b0, 8'd125, 24'hC3F000});
      row(F0, F2, F2, F2);
      chk("b0c3_y0", yo[0], {1'b1, 8'd123, 24'hBE2000});
      chk("b0c3_y2", yo[2], F0);

      // block 2 starts; block 1 columns follow with no gap
      row(F2, F4, F5, F7);
      chk("b1c0_y0", yo[0], {1'b0, 8'd129, 24'hC00000});
      chk("b1c0_y1", yo[1], F0);
      row(F2, F4, F5, F7);
      chk("b1c1_y0", yo[0], {1'b1, 8'd128, 24'hA73E00});

      // reset during row 2 of block 2
      reset = 1'b0;
      #2;
      chk_all_zero("midrst");
      @(posedge clk);
      #1;
      reset = 1'b1;

      row(F0, F2, F2, F2);
      chk("r0_yy0", yyo[0], {1'b0, 8'd128, 24'hC00000});
      chk("r0_y0", yo[0], F0);
      row(F0, F2, F2, F2);
      row(F0, F2, F2, F2);
      row(F0, F2, F2, F2);
      chk("r3_y0", yo[0], F0);
      row(F2, F4, F5, F7);
      chk("r4_y0", yo[0], {1'b0, 8'd129, 24'hC00000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
